output_pipeline: RTL

OUTPUT_PIPELINE -- requirements
Module: output_pipeline

---
 rtl/output_pipeline_if.sv | 26 ++
 rtl/output_pipeline.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/output_pipeline_if.sv
// Control, CDF-table, source-image and destination-image signals of the output pipeline.
// master = equalizer core, slave = surrounding memories and control.
interface output_pipeline_if;
  logic         start;
  logic [19:0]  cdf_min;
  logic         cdf_valid;
  logic [15:0]  m3ReadAddr;
  logic [127:0] m3ReadBus;
  logic [15:0]  m1ReadAddr;
  logic [127:0] m1ReadBus;
  logic [15:0]  m4WriteAddr;
  logic [127:0] m4WriteBus;
  logic         m4WE;
  logic         busy;
  logic         done;

  modport master (
    input  start, cdf_min, cdf_valid, m3ReadBus, m1ReadBus,
    output m3ReadAddr, m1ReadAddr, m4WriteAddr, m4WriteBus, m4WE, busy, done
  );

  modport slave (
    output start, cdf_min, cdf_valid, m3ReadBus, m1ReadBus,
    input  m3ReadAddr, m1ReadAddr, m4WriteAddr, m4WriteBus, m4WE, busy, done
  );
endinterface

// File: rtl/output_pipeline.sv
// Histogram-equalization output stage: builds a 256-entry LUT from the CDF, then remaps every image word.
// LUT build takes ~30 cycles per entry; MAP streams one word per cycle, write lands two cycles after its read.
module output_pipeline #(
  parameter int unsigned NUM_WORDS = 65536,
  parameter int unsigned CDF_BASE  = 0
) (
  input  logic              clock,
  input  logic              rst,
  output_pipeline_if.master bus
);
  localparam logic [20:0] TOTAL_PIX  = 21'(16 * NUM_WORDS);
  localparam logic [15:0] LAST_WORD  = 16'(NUM_WORDS - 1);
  localparam logic [15:0] CDF_BASE_A = 16'(CDF_BASE);

  typedef enum logic [2:0] {S_IDLE, S_LUT_RD, S_LUT_DIV, S_MAP, S_DRAIN, S_DONE} state_t;

  state_t       state_q, state_d;
  logic [7:0]   v_q, v_d;
  logic         rd_wait_q, rd_wait_d;
  logic [15:0]  m3_addr_q, m3_addr_d;
  logic [15:0]  m1_addr_q, m1_addr_d;
  logic [19:0]  cdf_min_q, cdf_min_d;
  logic [27:0]  num_q, num_d;
  logic [20:0]  rem_q, rem_d;
  logic [4:0]   cnt_q, cnt_d;
  logic         rd_vld_q, m4we_q;
  logic [15:0]  p1_addr_q, m4addr_q;
  logic [127:0] m4bus_q;
  logic [7:0]   lut_q [256];

  logic         lut_we, advance;
  logic [7:0]   lut_wdata;
  logic [19:0]  cdf_w, diff_w;
  logic [20:0]  den_w, rem_next_w;
  logic [27:0]  num_init_w, num_next_w;
  logic [21:0]  trial_w;
  logic         ge_w;
  logic [127:0] mapped_w;

  assign cdf_w      = bus.m3ReadBus[19:0];
  assign diff_w     = cdf_w - cdf_min_q;
  assign den_w      = TOTAL_PIX - {1'b0, cdf_min_q};
  // x*255 as (x<<8)-x keeps the numerator setup multiplier-free
  assign num_init_w = {diff_w, 8'd0} - {8'd0, diff_w};

  // Restoring divider: num_q shifts dividend bits out and quotient bits in
  assign trial_w    = {rem_q, num_q[27]};
  assign ge_w       = (trial_w >= {1'b0, den_w});
  assign rem_next_w = ge_w ? 21'(trial_w - {1'b0, den_w}) : trial_w[20:0];
  assign num_next_w = {num_q[26:0], ge_w};

  always_comb begin
    state_d   = state_q;
    v_d       = v_q;
    rd_wait_d = rd_wait_q;
    m3_addr_d = m3_addr_q;
    m1_addr_d = m1_addr_q;
    cdf_min_d = cdf_min_q;
    num_d     = num_q;
    rem_d     = rem_q;
    cnt_d     = cnt_q;
    lut_we    = 1'b0;
    lut_wdata = 8'd0;
    advance   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start && bus.cdf_valid) begin
          state_d   = S_LUT_RD;
          v_d       = 8'd0;
          rd_wait_d = 1'b0;
          m3_addr_d = CDF_BASE_A;
          m1_addr_d = 16'd0;
          cdf_min_d = bus.cdf_min;
        end
      end
      S_LUT_RD: begin
        rd_wait_d = ~rd_wait_q;
        if (rd_wait_q) begin
          if (den_w == 21'd0 || cdf_w < cdf_min_q) begin
            lut_we  = 1'b1;
            advance = 1'b1;
          end else begin
            num_d   = num_init_w;
            rem_d   = 21'd0;
            cnt_d   = 5'd0;
            state_d = S_LUT_DIV;
          end
        end
      end
      S_LUT_DIV: begin
        num_d = num_next_w;
        rem_d = rem_next_w;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd27) begin
          lut_we    = 1'b1;
          lut_wdata = (|num_next_w[27:8]) ? 8'hFF : num_next_w[7:0];
          advance   = 1'b1;
        end
      end
      S_MAP: begin
        if (m1_addr_q == LAST_WORD) state_d = S_DRAIN;
        else                        m1_addr_d = m1_addr_q + 16'd1;
      end
      S_DRAIN: begin
        if (m4we_q && !rd_vld_q) state_d = S_DONE;
      end
      S_DONE: begin
        if (!bus.start) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (advance) begin
      if (v_q == 8'hFF) begin
        state_d = S_MAP;
      end else begin
        state_d   = S_LUT_RD;
        v_d       = v_q + 8'd1;
        m3_addr_d = m3_addr_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      v_q       <= 8'd0;
      rd_wait_q <= 1'b0;
      m3_addr_q <= 16'd0;
      m1_addr_q <= 16'd0;
      cdf_min_q <= 20'd0;
      num_q     <= 28'd0;
      rem_q     <= 21'd0;
      cnt_q     <= 5'd0;
      rd_vld_q  <= 1'b0;
      p1_addr_q <= 16'd0;
      m4we_q    <= 1'b0;
      m4addr_q  <= 16'd0;
      m4bus_q   <= 128'd0;
    end else begin
      v_q       <= v_d;
      rd_wait_q <= rd_wait_d;
      m3_addr_q <= m3_addr_d;
      m1_addr_q <= m1_addr_d;
      cdf_min_q <= cdf_min_d;
      num_q     <= num_d;
      rem_q     <= rem_d;
      cnt_q     <= cnt_d;
      rd_vld_q  <= (state_q == S_MAP);
      p1_addr_q <= m1_addr_q;
      m4we_q    <= rd_vld_q;
      m4addr_q  <= p1_addr_q;
      if (rd_vld_q) m4bus_q <= mapped_w;
    end
  end

  always_ff @(posedge clock) begin
    if (lut_we) lut_q[v_q] <= lut_wdata;
  end

  always_comb begin
    mapped_w = '0;
    for (int i = 0; i < 16; i++) mapped_w[8*i +: 8] = lut_q[bus.m1ReadBus[8*i +: 8]];
  end

  assign bus.m3ReadAddr  = m3_addr_q;
  assign bus.m1ReadAddr  = m1_addr_q;
  assign bus.m4WriteAddr = m4addr_q;
  assign bus.m4WriteBus  = m4bus_q;
  assign bus.m4WE        = m4we_q;
  assign bus.busy        = (state_q != S_IDLE) && (state_q != S_DONE);
  assign bus.done        = (state_q == S_DONE);
endmodule
